// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank subtract sequencer.
// Holds the data width, the command opcode encoding and the
// controller state encoding so the top level and the bench agree on them.
package reg_bank_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SUB  = 2'b01,
    OP_READ = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_EXEC = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/reg_file_nx32.sv
// NREG x 32-bit register file.
// Ports:
//   clk, rst          : clock, synchronous active-high clear of every entry
//   rs_addr / rs_data : asynchronous read port A
//   rt_addr / rt_data : asynchronous read port B
//   wr_en, wr_addr,
//   wr_data           : synchronous write port
// Entry 0 always reads as zero and ignores writes.
module reg_file_nx32
  import reg_bank_pkg::*;
#(
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [AW-1:0]     rt_addr,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rs_data = (rs_addr == '0) ? '0 : mem[rs_addr];
  assign rt_data = (rt_addr == '0) ? '0 : mem[rt_addr];

endmodule

// File: rtl/reg_bank_sub_seq.sv
// Sequenced register bank with a 32-bit subtractor.
// One command at a time walks IDLE -> READ -> EXEC -> RESP:
//   LOAD rd <= imm, SUB rd <= rs - rt, READ returns rs, NOP returns 0.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   cmd_valid / cmd_ready          : command handshake
//   cmd_op, cmd_rd, cmd_rs, cmd_rt,
//   cmd_imm                        : command fields
//   rsp_valid / rsp_ready          : response handshake
//   rsp_data, rsp_cout, rsp_zero   : result, carry (1 = no borrow), zero flag
module reg_bank_sub_seq
  import reg_bank_pkg::*;
#(
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AW-1:0]     cmd_rd,
  input  logic [AW-1:0]     cmd_rs,
  input  logic [AW-1:0]     cmd_rt,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_cout,
  output logic              rsp_zero
);

  // A + ~B + 1 in DATA_W+1 bits; the top bit is the carry out.
  function automatic logic [DATA_W:0] sub_carry(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
  endfunction

  state_e state, state_nxt;

  op_e               op_p0;
  logic [AW-1:0]     rd_p0, rs_p0, rt_p0;
  logic [DATA_W-1:0] imm_p0;
  logic [DATA_W-1:0] opa_p1, opb_p1;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W:0]   sub_p1;
  logic [DATA_W-1:0] res_data;
  logic              res_cout;
  logic              wr_en;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ST_READ;
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: command capture on accept
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && cmd_valid) begin
      op_p0  <= op_e'(cmd_op);
      rd_p0  <= cmd_rd;
      rs_p0  <= cmd_rs;
      rt_p0  <= cmd_rt;
      imm_p0 <= cmd_imm;
    end
  end

  reg_file_nx32 #(
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (rs_p0),
    .rs_data (rf_a),
    .rt_addr (rt_p0),
    .rt_data (rf_b),
    .wr_en   (wr_en),
    .wr_addr (rd_p0),
    .wr_data (res_data)
  );

  // Stage p1: operand fetch
  always_ff @(posedge clk) begin
    if (state == ST_READ) begin
      opa_p1 <= rf_a;
      opb_p1 <= rf_b;
    end
  end

  assign sub_p1 = sub_carry(opa_p1, opb_p1);

  // Result select and write-back; reset suppresses the write in its cycle.
  always_comb begin
    res_data = '0;
    res_cout = 1'b0;
    wr_en    = 1'b0;
    case (op_p0)
      OP_LOAD: begin
        res_data = imm_p0;
        wr_en    = (state == ST_EXEC) && !rst;
      end
      OP_SUB: begin
        res_data = sub_p1[DATA_W-1:0];
        res_cout = sub_p1[DATA_W];
        wr_en    = (state == ST_EXEC) && !rst;
      end
      OP_READ: res_data = opa_p1;
      default: res_data = '0;
    endcase
  end

  // Stage p2: response registers, held until the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_cout <= 1'b0;
      rsp_zero <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_data <= res_data;
      rsp_cout <= res_cout;
      rsp_zero <= (res_data == '0);
    end
  end

endmodule

// File: tb/tb_reg_bank_sub_seq.sv
module tb_reg_bank_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_rd, cmd_rs, cmd_rt;
  logic [31:0] cmd_imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_cout;
  logic        rsp_zero;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [16];
  logic [31:0] last_data;
  logic        last_cout, last_zero;

  always #5 clk = ~clk;

  reg_bank_sub_seq #(.NREG(16), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .cmd_imm   (cmd_imm),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_zero  (rsp_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"},  rsp_data,  0);
    chk({tag, "_rsp_cout"},  rsp_cout,  0);
    chk({tag, "_rsp_zero"},  rsp_zero,  0);
  endtask

  // Issue one command, check it against the reference model, consume it.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [3:0] rt, input logic [31:0] imm, input int hold,
                        input logic noisy);
    logic [31:0] a, b, ed;
    logic        ec;
    int          n;
    a = model[rs];
    b = model[rt];
    ec = 1'b0;
    case (op)
      2'b00: ed = imm;
      2'b01: begin ed = a - b; ec = (a >= b); end
      2'b10: ed = a;
      default: ed = 32'h0;
    endcase

    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      if (noisy) rsp_ready = 1'($urandom_range(0, 1));
      tick(); n++;
    end
    chk("accept_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_imm = $urandom;

    n = 0;
    while (!rsp_valid && n < 20) begin
      chk("busy_cmd_ready", cmd_ready, 0);
      if (noisy) rsp_ready = 1'($urandom_range(0, 1));
      tick(); n++;
    end
    rsp_ready = 1'b0;
    chk("rsp_valid_seen", rsp_valid, 1);
    chk("latency", n, 2);

    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, ed);
      chk("hold_cmd_ready", cmd_ready, 0);
    end

    chk("rsp_data", rsp_data, ed);
    chk("rsp_cout", rsp_cout, ec);
    chk("rsp_zero", rsp_zero, (ed == 32'h0));
    last_data = rsp_data;
    last_cout = rsp_cout;
    last_zero = rsp_zero;

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);

    if ((op == 2'b00 || op == 2'b01) && rd != 4'd0) model[rd] = ed;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 2'b11; cmd_rd = 0; cmd_rs = 0; cmd_rt = 0; cmd_imm = 0;
    clear_model();
    last_data = 0; last_cout = 0; last_zero = 0;
    tick(); tick();
    rst = 1'b0;
    check_idle_reset("reset");

    // Basic subtract and readback
    do_cmd(2'b00, 4'd1, 4'd0, 4'd0, 32'h0000000A, 0, 1'b0);
    do_cmd(2'b00, 4'd2, 4'd0, 4'd0, 32'h00000003, 0, 1'b0);
    do_cmd(2'b01, 4'd3, 4'd1, 4'd2, 32'h0, 0, 1'b0);
    chk("sub7_data", last_data, 32'h7);
    chk("sub7_cout", last_cout, 1);
    chk("sub7_zero", last_zero, 0);
    do_cmd(2'b10, 4'd0, 4'd3, 4'd0, 32'h0, 0, 1'b0);
    chk("read_r3", last_data, 32'h7);

    // Wrap-around borrow
    do_cmd(2'b00, 4'd1, 4'd0, 4'd0, 32'h00000003, 0, 1'b0);
    do_cmd(2'b00, 4'd2, 4'd0, 4'd0, 32'h0000000A, 0, 1'b0);
    do_cmd(2'b01, 4'd4, 4'd1, 4'd2, 32'h0, 0, 1'b0);
    chk("wrap_data", last_data, 32'hFFFFFFF9);
    chk("wrap_cout", last_cout, 0);

    // Register zero
    do_cmd(2'b00, 4'd0, 4'd0, 4'd0, 32'h12345678, 0, 1'b0);
    chk("load_r0_data", last_data, 32'h12345678);
    do_cmd(2'b10, 4'd0, 4'd0, 4'd0, 32'h0, 0, 1'b0);
    chk("read_r0", last_data, 32'h0);

    // Self-subtract with stalled consumer
    do_cmd(2'b01, 4'd5, 4'd1, 4'd1, 32'h0, 5, 1'b0);
    chk("self_data", last_data, 32'h0);
    chk("self_cout", last_cout, 1);
    chk("self_zero", last_zero, 1);

    // NOP
    do_cmd(2'b11, 4'd7, 4'd1, 4'd2, 32'hDEADBEEF, 0, 1'b0);
    chk("nop_data", last_data, 32'h0);

    // Reset during EXEC of SUB R6
    cmd_op = 2'b01; cmd_rd = 4'd6; cmd_rs = 4'd2; cmd_rt = 4'd1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    check_idle_reset("rst_exec");
    do_cmd(2'b10, 4'd0, 4'd6, 4'd0, 32'h0, 0, 1'b0);
    chk("rst_read_r6", last_data, 32'h0);
    do_cmd(2'b10, 4'd0, 4'd1, 4'd0, 32'h0, 0, 1'b0);
    chk("rst_read_r1", last_data, 32'h0);

    // Reset with a pending response
    do_cmd(2'b00, 4'd9, 4'd0, 4'd0, 32'h55AA55AA, 0, 1'b0);
    cmd_op = 2'b10; cmd_rs = 4'd9; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("pend_valid", rsp_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    check_idle_reset("rst_resp");

    // Back-to-back with rsp_ready held high
    rsp_ready = 1'b1;
    cmd_op = 2'b00; cmd_rd = 4'd7; cmd_rs = 0; cmd_rt = 0; cmd_imm = 32'hCAFE0001;
    cmd_valid = 1'b1;
    tick();                                   // edge N: accepted
    chk("b2b_n_ready", cmd_ready, 0);
    chk("b2b_n_valid", rsp_valid, 0);
    tick();                                   // edge N+1
    chk("b2b_n1_valid", rsp_valid, 0);
    cmd_op = 2'b10; cmd_rs = 4'd7;
    tick();                                   // edge N+2: response sampled high at N+3
    chk("b2b_n2_valid", rsp_valid, 1);
    chk("b2b_n2_data", rsp_data, 32'hCAFE0001);
    chk("b2b_n2_ready", cmd_ready, 0);
    tick();                                   // edge N+3: response taken
    chk("b2b_n3_valid", rsp_valid, 0);
    chk("b2b_n3_ready", cmd_ready, 1);
    tick();                                   // edge N+4: next command accepted
    chk("b2b_n4_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    tick(); tick();
    chk("b2b_raw_valid", rsp_valid, 1);
    chk("b2b_raw_data", rsp_data, 32'hCAFE0001);
    tick();
    rsp_ready = 1'b0;
    model[7] = 32'hCAFE0001;

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      logic [1:0]  op;
      logic [31:0] imm;
      op  = 2'($urandom);
      imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      do_cmd(op, 4'($urandom), 4'($urandom), 4'($urandom), imm,
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
